// File: rtl/tetris_input_ctrl_pkg.sv
// Shared defaults, action bit positions and the gravity-period helper for the input block.
package tetris_input_ctrl_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000;
    localparam int unsigned DEF_FALL_BASE       = 50_000_000;
    localparam int unsigned DEF_FALL_STEP       = 4_000_000;
    localparam int unsigned DEF_FALL_MIN        = 5_000_000;

    // Bit positions in the 4-bit action vector; higher bit wins arbitration.
    localparam int ACT_ROTATE = 3;
    localparam int ACT_LEFT   = 2;
    localparam int ACT_RIGHT  = 1;
    localparam int ACT_DROP   = 0;

    function automatic logic [31:0] fall_period(
        input logic [3:0]  level,
        input logic [31:0] base,
        input logic [31:0] step,
        input logic [31:0] fmin
    );
        logic [31:0] prod;
        logic [31:0] diff;
        logic [31:0] result;
        prod = {28'd0, level} * step;
        diff = base - prod;
        if (prod >= base) begin
            result = fmin;
        end else if (diff < fmin) begin
            result = fmin;
        end else begin
            result = diff;
        end
        return result;
    endfunction

endpackage

// File: rtl/tetris_btn_debounce.sv
// Raw button -> 2-flop sync -> stable-count debounce -> registered rising-edge pulse.
// Latency: rise is high DEBOUNCE_CYCLES+2 edges after the first sampling edge; no backpressure.
module tetris_btn_debounce
    import tetris_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic held,
    output logic rise
);

    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES) - 32'd1;

    logic        sync_1;
    logic        sync_2;
    logic        held_q;
    logic [31:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            held       <= 1'b0;
            held_q     <= 1'b0;
            rise       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            held_q <= held;
            rise   <= held & ~held_q;
            // Any cycle that agrees with the debounced level restarts the count.
            if (sync_2 != held) begin
                if (stable_cnt == DB_LAST) begin
                    held       <= sync_2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 32'd1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Turns four raw buttons into arbitrated one-cycle action pulses and generates the gravity tick.
// Latency: DEBOUNCE_CYCLES+3 edges press-to-pulse; accept=0 drops all requests and freezes the fall timer.
module tetris_input_ctrl
    import tetris_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned FALL_BASE       = DEF_FALL_BASE,
    parameter int unsigned FALL_STEP       = DEF_FALL_STEP,
    parameter int unsigned FALL_MIN        = DEF_FALL_MIN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rotate,
    input  logic       btn_drop,
    input  logic [3:0] level,
    input  logic       accept,
    output logic       rotate,
    output logic       move_left,
    output logic       move_right,
    output logic       move_tobottom,
    output logic       en_fall
);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY) - 32'd1;
    localparam logic [31:0] RP_LAST = 32'(REPEAT_PERIOD) - 32'd1;

    logic       rise_rot;
    logic       rise_drop;
    logic [1:0] held_unused;
    logic [1:0] rpt_held;
    logic [1:0] rpt_rise;

    tetris_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .rst_n(rst_n), .btn(btn_left), .held(rpt_held[0]), .rise(rpt_rise[0])
    );
    tetris_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .rst_n(rst_n), .btn(btn_right), .held(rpt_held[1]), .rise(rpt_rise[1])
    );
    tetris_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rotate (
        .clk(clk), .rst_n(rst_n), .btn(btn_rotate), .held(held_unused[0]), .rise(rise_rot)
    );
    tetris_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_drop (
        .clk(clk), .rst_n(rst_n), .btn(btn_drop), .held(held_unused[1]), .rise(rise_drop)
    );

    // Index 0 is left, 1 is right.
    rpt_state_t  rpt_state     [2];
    rpt_state_t  rpt_state_nxt [2];
    logic [31:0] rpt_cnt       [2];
    logic [31:0] rpt_cnt_nxt   [2];
    logic [1:0]  rpt_req;
    logic        both_held;

    assign both_held = rpt_held[0] & rpt_held[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rpt_state[i] <= RPT_IDLE;
                rpt_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rpt_state[i] <= rpt_state_nxt[i];
                rpt_cnt[i]   <= rpt_cnt_nxt[i];
            end
        end
    end

    // Holding both directions freezes the counters so neither side auto-repeats.
    always_comb begin
        rpt_req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rpt_state_nxt[i] = rpt_state[i];
            rpt_cnt_nxt[i]   = rpt_cnt[i];
            if (!rpt_held[i]) begin
                rpt_state_nxt[i] = RPT_IDLE;
                rpt_cnt_nxt[i]   = '0;
            end else begin
                case (rpt_state[i])
                    RPT_IDLE: begin
                        if (rpt_rise[i]) begin
                            rpt_state_nxt[i] = RPT_DELAY;
                            rpt_cnt_nxt[i]   = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (!both_held) begin
                            if (rpt_cnt[i] == RD_LAST) begin
                                rpt_state_nxt[i] = RPT_REPEAT;
                                rpt_cnt_nxt[i]   = '0;
                                rpt_req[i]       = 1'b1;
                            end else begin
                                rpt_cnt_nxt[i] = rpt_cnt[i] + 32'd1;
                            end
                        end
                    end
                    RPT_REPEAT: begin
                        if (!both_held) begin
                            if (rpt_cnt[i] == RP_LAST) begin
                                rpt_cnt_nxt[i] = '0;
                                rpt_req[i]     = 1'b1;
                            end else begin
                                rpt_cnt_nxt[i] = rpt_cnt[i] + 32'd1;
                            end
                        end
                    end
                    default: begin
                        rpt_state_nxt[i] = RPT_IDLE;
                        rpt_cnt_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    logic [3:0] act_new;
    logic [3:0] act_req;
    logic [3:0] act_win;
    logic [3:0] pend;
    logic [3:0] act;

    always_comb begin
        act_new             = 4'b0000;
        act_new[ACT_ROTATE] = rise_rot;
        act_new[ACT_LEFT]   = rpt_rise[0] | rpt_req[0];
        act_new[ACT_RIGHT]  = rpt_rise[1] | rpt_req[1];
        act_new[ACT_DROP]   = rise_drop;
        act_req             = act_new | pend;
        act_win             = 4'b0000;
        if (act_req[ACT_ROTATE]) begin
            act_win[ACT_ROTATE] = 1'b1;
        end else if (act_req[ACT_LEFT]) begin
            act_win[ACT_LEFT] = 1'b1;
        end else if (act_req[ACT_RIGHT]) begin
            act_win[ACT_RIGHT] = 1'b1;
        end else if (act_req[ACT_DROP]) begin
            act_win[ACT_DROP] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act  <= 4'b0000;
            pend <= 4'b0000;
        end else if (!accept) begin
            act  <= 4'b0000;
            pend <= 4'b0000;
        end else begin
            act  <= act_win;
            pend <= act_req & ~act_win;
        end
    end

    assign rotate        = act[ACT_ROTATE];
    assign move_left     = act[ACT_LEFT];
    assign move_right    = act[ACT_RIGHT];
    assign move_tobottom = act[ACT_DROP];

    logic [31:0] fall_cnt;
    logic [31:0] p_reg;
    logic [31:0] p_calc;
    logic [31:0] p_eff;
    logic        p_loaded;
    logic        fall_wrap;

    always_comb begin
        p_calc    = fall_period(level, 32'(FALL_BASE), 32'(FALL_STEP), 32'(FALL_MIN));
        p_eff     = p_loaded ? p_reg : p_calc;
        fall_wrap = (fall_cnt == p_eff - 32'd1);
    end

    // The period is only re-latched at a wrap, so a level change lands on the next period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_cnt <= '0;
            p_reg    <= '0;
            p_loaded <= 1'b0;
            en_fall  <= 1'b0;
        end else begin
            p_loaded <= 1'b1;
            if (!p_loaded || (accept && fall_wrap)) begin
                p_reg <= p_calc;
            end
            if (!accept) begin
                en_fall <= 1'b0;
            end else if (fall_wrap) begin
                fall_cnt <= '0;
                en_fall  <= 1'b1;
            end else begin
                fall_cnt <= fall_cnt + 32'd1;
                en_fall  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed-vector bench for tetris_input_ctrl with small timing constants.
module tb_tetris_input_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_rotate = 1'b0;
    logic       btn_drop = 1'b0;
    logic [3:0] level = 4'd0;
    logic       accept = 1'b1;
    logic       rotate;
    logic       move_left;
    logic       move_right;
    logic       move_tobottom;
    logic       en_fall;
    logic [3:0] acts;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign acts = {rotate, move_left, move_right, move_tobottom};

    tetris_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3),
        .FALL_BASE(20),
        .FALL_STEP(3),
        .FALL_MIN(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_rotate(btn_rotate),
        .btn_drop(btn_drop),
        .level(level),
        .accept(accept),
        .rotate(rotate),
        .move_left(move_left),
        .move_right(move_right),
        .move_tobottom(move_tobottom),
        .en_fall(en_fall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After return, the next posedge is edge 1 after reset release.
    task automatic do_reset();
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_rotate = 1'b0;
        btn_drop   = 1'b0;
        accept     = 1'b1;
        level      = 4'd0;
        rst_n      = 1'b0;
        repeat (3) tick();
        chk("rst_acts", {28'd0, acts}, 32'd0);
        chk("rst_fall", {31'd0, en_fall}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: single press, then a short bounce
        do_reset();
        btn_rotate = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            tick();
            chk("t1_press", {28'd0, acts}, (i == 7) ? 32'h8 : 32'h0);
        end
        btn_rotate = 1'b0;
        repeat (10) tick();
        btn_rotate = 1'b1; tick();
        tick();
        btn_rotate = 1'b0; tick();
        btn_rotate = 1'b1; tick();
        btn_rotate = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t1_bounce", {28'd0, acts}, 32'h0);
        end

        // 2: left held 30 cycles with auto-repeat
        do_reset();
        btn_left = 1'b1;
        for (int i = 0; i <= 45; i++) begin
            if (i == 30) btn_left = 1'b0;
            tick();
            chk("t2_repeat", {28'd0, acts},
                ((i == 7) || (i >= 17 && i <= 35 && ((i - 17) % 3) == 0)) ? 32'h4 : 32'h0);
        end

        // 3: simultaneous rotate, left, drop
        do_reset();
        btn_rotate = 1'b1;
        btn_left   = 1'b1;
        btn_drop   = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            logic [3:0] e;
            tick();
            e = (i == 7) ? 4'h8 : (i == 8) ? 4'h4 : (i == 9) ? 4'h1 : 4'h0;
            chk("t3_arb", {28'd0, acts}, {28'd0, e});
        end

        // 4: fall periods 20, 14, 5 with mid-period level changes
        do_reset();
        for (int k = 1; k <= 105; k++) begin
            logic e;
            if (k == 51) level = 4'd2;
            if (k == 81) level = 4'd15;
            tick();
            e = (k == 20) || (k == 40) || (k == 60) || (k == 74) || (k == 88) ||
                (k == 93) || (k == 98) || (k == 103);
            chk("t4_fall", {31'd0, en_fall}, {31'd0, e});
        end

        // 5: accept low with a pending drop and fall count at 10
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) begin
                btn_rotate = 1'b1;
                btn_drop   = 1'b1;
            end
            if (k == 11) accept = 1'b0;
            if (k == 19) accept = 1'b1;
            tick();
            chk("t5_acts", {28'd0, acts}, (k == 10) ? 32'h8 : 32'h0);
            chk("t5_fall", {31'd0, en_fall}, (k == 28) ? 32'h1 : 32'h0);
        end

        // 6: left and right held together, then reset mid-hold
        do_reset();
        btn_left  = 1'b1;
        btn_right = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            tick();
            chk("t6_both", {28'd0, acts}, (k == 8) ? 32'h4 : (k == 9) ? 32'h2 : 32'h0);
        end
        btn_rotate = 1'b1;
        for (int k = 42; k <= 49; k++) begin
            tick();
            chk("t6_rot", {28'd0, acts}, (k == 49) ? 32'h8 : 32'h0);
        end
        rst_n = 1'b0;
        #1;
        chk("t6_async_acts", {28'd0, acts}, 32'h0);
        chk("t6_async_fall", {31'd0, en_fall}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] e;
            tick();
            e = (k == 8) ? 4'h8 : (k == 9) ? 4'h4 : (k == 10) ? 4'h2 : 4'h0;
            chk("t6_fresh", {28'd0, acts}, {28'd0, e});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
